// File: rtl/ext_domain_power_sequencer.sv
// rtl/ext_domain_power_sequencer.sv - power switch / isolation / clock / reset sequencer for one external domain
module ext_domain_power_sequencer #(
  parameter int SWITCH_ACK_TIMEOUT = 64,
  parameter int ISO_SETTLE_CYCLES  = 4,
  parameter int RST_HOLD_CYCLES    = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       domain_on_req_i,
  input  logic       powergate_switch_ack_i,
  input  logic       clear_err_i,
  output logic       powergate_switch_o,
  output logic       iso_o,
  output logic       clk_en_o,
  output logic       domain_rst_no,
  output logic       powered_o,
  output logic       busy_o,
  output logic       timeout_err_o,
  output logic [2:0] state_o
);

  localparam int MAX_A   = (SWITCH_ACK_TIMEOUT > ISO_SETTLE_CYCLES) ? SWITCH_ACK_TIMEOUT : ISO_SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > RST_HOLD_CYCLES) ? MAX_A : RST_HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Counter holds "remaining cycles minus one"; zero means this is the last cycle of the step.
  localparam logic [CNT_W-1:0] LD_ACK = CNT_W'(SWITCH_ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LD_ISO = CNT_W'(ISO_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_RST = CNT_W'(RST_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_UP_SWITCH = 3'd1,
    ST_UP_ISO    = 3'd2,
    ST_UP_CLK    = 3'd3,
    ST_ON        = 3'd4,
    ST_DN_RST    = 3'd5,
    ST_DN_ISO    = 3'd6,
    ST_DN_SWITCH = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;
  logic             err_set;
  logic             expired;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (err_set) begin
        err_q <= 1'b1;
      end else if (clear_err_i) begin
        err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    expired = (cnt_q == '0);
    case (state_q)
      ST_OFF:       if (domain_on_req_i) state_d = ST_UP_SWITCH;
      ST_UP_SWITCH: begin
        // An ack seen on the final timeout cycle still counts as success.
        if (powergate_switch_ack_i) begin
          state_d = ST_UP_ISO;
        end else if (expired) begin
          err_set = 1'b1;
          state_d = ST_DN_SWITCH;
        end
      end
      ST_UP_ISO:    if (expired) state_d = ST_UP_CLK;
      ST_UP_CLK:    if (expired) state_d = ST_ON;
      ST_ON:        if (!domain_on_req_i) state_d = ST_DN_RST;
      ST_DN_RST:    if (expired) state_d = ST_DN_ISO;
      ST_DN_ISO:    if (expired) state_d = ST_DN_SWITCH;
      ST_DN_SWITCH: begin
        if (!powergate_switch_ack_i) begin
          state_d = ST_OFF;
        end else if (expired) begin
          err_set = 1'b1;
          state_d = ST_OFF;
        end
      end
      default:      state_d = ST_OFF;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        ST_UP_SWITCH, ST_DN_SWITCH: cnt_d = LD_ACK;
        ST_UP_ISO, ST_DN_ISO:       cnt_d = LD_ISO;
        ST_UP_CLK, ST_DN_RST:       cnt_d = LD_RST;
        default:                    cnt_d = '0;
      endcase
    end else if (!expired) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    powergate_switch_o = 1'b0;
    iso_o              = 1'b1;
    clk_en_o           = 1'b0;
    domain_rst_no      = 1'b0;
    powered_o          = 1'b0;
    busy_o             = 1'b1;
    case (state_q)
      ST_OFF:       busy_o = 1'b0;
      ST_UP_SWITCH: powergate_switch_o = 1'b1;
      ST_UP_ISO: begin
        powergate_switch_o = 1'b1;
        iso_o              = 1'b0;
      end
      ST_UP_CLK, ST_DN_RST: begin
        powergate_switch_o = 1'b1;
        iso_o              = 1'b0;
        clk_en_o           = 1'b1;
      end
      ST_ON: begin
        powergate_switch_o = 1'b1;
        iso_o              = 1'b0;
        clk_en_o           = 1'b1;
        domain_rst_no      = 1'b1;
        powered_o          = 1'b1;
        busy_o             = 1'b0;
      end
      ST_DN_ISO:    powergate_switch_o = 1'b1;
      default:      powergate_switch_o = 1'b0;
    endcase
  end

  assign timeout_err_o = err_q;
  assign state_o       = state_q;

endmodule
